// File: rtl/sdram_mport_arbiter.sv
// sdram_mport_arbiter: N-port front end for the single-client SDRAM controller.
// Grants one client burst at a time (round robin), forwards the burst request to the
// controller, counts per-word acks for end of burst and routes acks/read data back.
// Optional macro SDRAM_ARB_PRIO_EN: port 0 wins arbitration whenever it requests;
// the remaining ports keep round robin among themselves.
module sdram_mport_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int LEN_W     = 10
) (
  input  logic                        sys_clk_i,
  input  logic                        rst_n_i,
  input  logic                        sdram_init_end_i,
  input  logic [NUM_PORTS-1:0]        port_req_i,
  input  logic [NUM_PORTS-1:0]        port_wr_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr_i,
  input  logic [NUM_PORTS*LEN_W-1:0]  port_len_i,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wr_data_i,
  output logic [NUM_PORTS-1:0]        port_ack_o,
  output logic [DATA_W-1:0]           port_rd_data_o,
  output logic [NUM_PORTS-1:0]        port_done_o,
  output logic [NUM_PORTS-1:0]        port_grant_o,
  output logic                        sdram_wr_req_o,
  output logic                        sdram_rd_req_o,
  output logic [ADDR_W-1:0]           sdram_wr_addr_o,
  output logic [ADDR_W-1:0]           sdram_rd_addr_o,
  output logic [LEN_W-1:0]            sdram_wr_length_o,
  output logic [LEN_W-1:0]            sdram_rd_length_o,
  output logic [DATA_W-1:0]           sdram_wr_data_o,
  input  logic                        sdram_wr_ack_i,
  input  logic                        sdram_rd_ack_i,
  input  logic [DATA_W-1:0]           sdram_rd_data_i
);

  localparam int unsigned NP    = NUM_PORTS;
  localparam int          PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic              gwr;
  logic [ADDR_W-1:0] gaddr;
  logic [LEN_W-1:0]  glen;
  logic [LEN_W-1:0]  cnt;

  logic              found;
  logic [PTR_W-1:0]  pick;
  logic [PTR_W-1:0]  probe;
  logic [NUM_PORTS-1:0] rr_req;
  int unsigned       slot;
  logic [LEN_W-1:0]  pick_len;
  logic [NUM_PORTS-1:0] gsel;

  logic in_burst;
  logic dir_ack;
  logic last_word;

  // Pick the first requester at or after rr_ptr+1 (port 0 first when prioritised)
  always_comb begin
    found  = 1'b0;
    pick   = '0;
    probe  = '0;
    slot   = 0;
    rr_req = port_req_i;
`ifdef SDRAM_ARB_PRIO_EN
    rr_req[0] = 1'b0;
    if (port_req_i[0]) found = 1'b1;
`endif
    for (int unsigned i = 0; i < NP; i++) begin
      slot  = (32'(rr_ptr) + 32'd1 + i) % NP;
      probe = PTR_W'(slot);
      if (!found && rr_req[probe]) begin
        found = 1'b1;
        pick  = probe;
      end
    end
  end

  assign pick_len = port_len_i[pick*LEN_W +: LEN_W];

  // One-hot view of the latched grant index
  always_comb begin
    gsel       = '0;
    gsel[gidx] = 1'b1;
  end

  assign in_burst  = (state == ST_BURST);
  assign dir_ack   = in_burst & (gwr ? sdram_wr_ack_i : sdram_rd_ack_i);
  // Request drops in the cycle of the final ack so the controller never starts another burst
  assign last_word = dir_ack & (cnt == glen - LEN_W'(1));

  assign sdram_wr_req_o    = in_burst & gwr & ~last_word;
  assign sdram_rd_req_o    = in_burst & ~gwr & ~last_word;
  assign sdram_wr_addr_o   = gaddr;
  assign sdram_rd_addr_o   = gaddr;
  assign sdram_wr_length_o = glen;
  assign sdram_rd_length_o = glen;
  assign sdram_wr_data_o   = in_burst ? port_wr_data_i[gidx*DATA_W +: DATA_W] : '0;

  assign port_grant_o   = (in_burst || state == ST_DONE) ? gsel : '0;
  assign port_ack_o     = dir_ack ? gsel : '0;
  assign port_done_o    = (state == ST_DONE) ? gsel : '0;
  assign port_rd_data_o = sdram_rd_data_i;

  // Sequencer: wait for init, arbitrate, count burst words, retire the grant
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= ST_IDLE;
      rr_ptr <= PTR_W'(NP - 1);
      gidx   <= '0;
      gwr    <= 1'b0;
      gaddr  <= '0;
      glen   <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sdram_init_end_i) state <= ST_ARB;
        end
        ST_ARB: begin
          if (found) begin
            gidx  <= pick;
            gwr   <= port_wr_i[pick];
            gaddr <= port_addr_i[pick*ADDR_W +: ADDR_W];
            glen  <= pick_len;
            cnt   <= '0;
            state <= (pick_len == '0) ? ST_DONE : ST_BURST;
          end
        end
        ST_BURST: begin
          if (dir_ack) begin
            if (last_word) begin
              cnt   <= '0;
              state <= ST_DONE;
            end else begin
              cnt <= cnt + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
`ifdef SDRAM_ARB_PRIO_EN
          if (gidx != '0) rr_ptr <= gidx;
`else
          rr_ptr <= gidx;
`endif
          state <= ST_ARB;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
